// File: rtl/exibe_sequencia.sv
// Sequence playback for the memory game: shows stored items 0..limite on the LEDs.
// Optional abort input enabled by defining EXIBE_ABORTA_EN.
module exibe_sequencia #(
   parameter int T_ACESO   = 1000,
   parameter int T_APAGADO = 250
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [3:0] limite,
   input  logic [3:0] dado_memoria,
`ifdef EXIBE_ABORTA_EN
   input  logic       abortar,
`endif
   output logic [3:0] endereco,
   output logic [3:0] leds,
   output logic       ocupado,
   output logic       pronto,
   output logic [3:0] db_estado
);

   typedef enum logic [3:0] {
      INICIAL = 4'h0,
      PREPARA = 4'h1,
      ACESO   = 4'h2,
      APAGADO = 4'h3,
      PROXIMO = 4'h4,
      FIM     = 4'hF
   } estado_t;

   localparam logic [15:0] ACESO_FIM   = 16'(T_ACESO - 1);
   localparam logic [15:0] APAGADO_FIM = 16'(T_APAGADO - 1);

   estado_t     estado, estado_n;
   logic [15:0] timer, timer_n;
   logic [3:0]  end_n;
   logic [3:0]  leds_n;
   logic [3:0]  lim_q, lim_n;

   // State and datapath registers; reset returns everything to idle at once.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado   <= INICIAL;
         timer    <= '0;
         endereco <= '0;
         leds     <= '0;
         lim_q    <= '0;
      end else begin
         estado   <= estado_n;
         timer    <= timer_n;
         endereco <= end_n;
         leds     <= leds_n;
         lim_q    <= lim_n;
      end
   end

   // Next-state and next-datapath values for each playback phase.
   always_comb begin
      estado_n = estado;
      timer_n  = timer;
      end_n    = endereco;
      leds_n   = leds;
      lim_n    = lim_q;
      case (estado)
         INICIAL: begin
            end_n   = '0;
            leds_n  = '0;
            timer_n = '0;
            if (iniciar) begin
               lim_n    = limite;
               estado_n = PREPARA;
            end
         end
         PREPARA: begin
            leds_n   = dado_memoria;
            timer_n  = '0;
            estado_n = ACESO;
         end
         ACESO: begin
            if (timer == ACESO_FIM) begin
               leds_n   = '0;
               timer_n  = '0;
               estado_n = APAGADO;
            end else begin
               timer_n = timer + 16'd1;
            end
         end
         APAGADO: begin
            if (timer == APAGADO_FIM) begin
               timer_n  = '0;
               estado_n = (endereco == lim_q) ? FIM : PROXIMO;
            end else begin
               timer_n = timer + 16'd1;
            end
         end
         PROXIMO: begin
            end_n    = endereco + 4'd1;
            estado_n = PREPARA;
         end
         FIM: begin
            end_n    = '0;
            estado_n = INICIAL;
         end
         default: begin
            end_n    = '0;
            leds_n   = '0;
            timer_n  = '0;
            estado_n = INICIAL;
         end
      endcase
`ifdef EXIBE_ABORTA_EN
      if (abortar && (estado == PREPARA || estado == ACESO ||
                      estado == APAGADO || estado == PROXIMO)) begin
         leds_n   = '0;
         timer_n  = '0;
         estado_n = FIM;
      end
`endif
   end

   // Status outputs decode only the state register.
   always_comb begin
      ocupado   = (estado != INICIAL);
      pronto    = (estado == FIM);
      db_estado = estado;
   end

endmodule

// File: doc/exibe_sequencia.md
# exibe_sequencia

Sequence playback unit for the memory game: on request it reads the stored sequence from index 0 up to the current round limit and shows each value on the player LEDs for a fixed on-time, followed by a dark gap. It drives the memory address, owns the LED register, and tells the control unit when playback is finished. It complements the player-input path, which reads `chaves` and compares against the same memory.

## Interface
Parameters:
- `T_ACESO`, default 1000: clock cycles each value stays lit. Range 1..65535.
- `T_APAGADO`, default 250: dark cycles after each value. Range 1..65535.

Ports:
- `clock`  in  1  system clock, single clock domain; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces the idle state immediately.
- `iniciar`  in  1  start request; level, sampled only in INICIAL.
- `limite`  in  4  index of the last item to show (0..15); sampled on start.
- `dado_memoria`  in  4  memory read data; valid one cycle after `endereco` changes.
- `endereco`  out  4  memory read address (registered).
- `leds`  out  4  LED drive (registered).
- `ocupado`  out  1  high in every state except INICIAL.
- `pronto`  out  1  one-cycle pulse when playback ends.
- `db_estado`  out  4  state code, for the `hexa7seg` display.
- `abortar`  in  1  present only with `EXIBE_ABORTA_EN`.

## Operation
- **INICIAL (0).**
  - `endereco` = 0, `leds` = 0, timer = 0.
  - When `iniciar` = 1: latch `limite`, keep address 0, go to PREPARA.
- **PREPARA (1).**
  - Lasts one cycle, so a memory with a 1-cycle synchronous read presents its data.
  - On exit, `leds` ← `dado_memoria` and the timer is cleared. Go to ACESO.
- **ACESO (2).**
  - Lasts `T_ACESO` cycles with `leds` held.
  - On exit, `leds` ← 0 and the timer is cleared. Go to APAGADO.
- **APAGADO (3).**
  - Lasts `T_APAGADO` cycles.
  - If `endereco` == latched limite, go to FIM. Otherwise go to PROXIMO.
- **PROXIMO (4).**
  - Lasts one cycle. `endereco` ← `endereco` + 1, then go to PREPARA.
- **FIM (F).**
  - `pronto` = 1 for one cycle, `endereco` ← 0, then go to INICIAL.
- **Illegal state codes** go to INICIAL on the next edge.
- **Timer:** 16-bit, counts up from 0. A state ends on the cycle where timer == T−1.
- **Input stability:**
  - Changes to `iniciar` or `limite` while `ocupado` = 1 are ignored.
  - Changes to `dado_memoria` outside PREPARA do not affect `leds`.
- **`iniciar` held high:** playback restarts right after FIM. `pronto` still pulses once per playback.
- **`limite` = 0:** exactly one item is shown, then FIM.
- **`limite` = 15:** the address reaches 15 and does not wrap; FIM follows item 15.

## Timing
- Reset values: `endereco` = 0, `leds` = 0, `ocupado` = 0, `pronto` = 0, `db_estado` = 0. Reset takes effect asynchronously and at any point mid-playback.
- Let E0 be the edge that samples `iniciar` = 1.
  - Item k is loaded into `leds` at edge E0 + 1 + k·(T_ACESO + T_APAGADO + 2).
  - `leds` returns to 0 at that load edge + T_ACESO.
  - FIM occupies the cycle that starts at edge E0 + (L+1)·(1 + T_ACESO + T_APAGADO) + L, where L = latched limite.
- `ocupado` rises at E0 and falls one edge after the FIM cycle.
- Outputs are fully registered; there is no combinational path from inputs to outputs.

## Configuration
- `EXIBE_ABORTA_EN` defined:
  - Adds input port `abortar`.
  - When `abortar` = 1 in PREPARA, ACESO, APAGADO or PROXIMO, the next edge sets `leds` ← 0 and goes to FIM, which pulses `pronto` as normal.
  - `abortar` has no effect in INICIAL or FIM.
  - `reset` takes priority over `abortar`.
- Macro undefined: the port is absent and playback always runs to completion.

## Test plan
All scenarios use T_ACESO = 3 and T_APAGADO = 2.
- **Reset values:** apply reset → every output is 0 and `db_estado` = 0. Hold `iniciar` = 0 → the outputs stay idle.
- **Three-item playback:** memory = {5, A, 3}, `limite` = 2, pulse `iniciar` at E0 →
  - `leds` = 5 at E1, A at E8, 3 at E15; each value lasts 3 cycles.
  - `endereco` steps 0, 1, 2.
  - `pronto` pulses in the cycle after E20.
  - `ocupado` is high throughout.
- **Single item:** `limite` = 0, memory[0] = F → one F lasting 3 cycles, then `pronto` after E6.
- **Input changes mid-playback:** change `limite` to 7 and pulse `iniciar` during ACESO → no change to sequence length or timing.
- **Reset mid-playback:** assert `reset` during APAGADO of item 1 → immediately `leds` = 0, `endereco` = 0, INICIAL, with no `pronto`. A new `iniciar` then replays from item 0.
- **Abort (with `EXIBE_ABORTA_EN`):** `abortar` = 1 during ACESO of item 0, `limite` = 2 → at the next edge `leds` = 0 and the state is FIM. `pronto` pulses one cycle and the block returns to INICIAL.
